// File: rtl/spi_mem_port.sv
// spi_mem_port: SPI master bridging CPU fetch/load/store requests to a serial
// flash (instruction reads, cs1) and a serial RAM (data reads and all writes, cs2).
// Each transfer is an 8-bit command (0x03 read, 0x02 write), a 24-bit address and
// 1/2/4 data bytes. SPI mode 0, two clk cycles per bit.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start_request       - held high by the CPU for the whole transaction
//   is_write            - 1 = write, 0 = read
//   is_data_fetch       - 1 = RAM data read, 0 = flash instruction read
//   num_bytes           - 1, 2 or 4; anything else completes with no SPI traffic
//   target_address      - byte address, [23:0] transmitted
//   write_value         - write bytes, sent from [31:24] downward
//   miso                - serial data from memory
//   sclk, mosi          - SPI clock / data out
//   cs1, cs2            - flash / RAM chip selects, active low
//   fetched_instruction - last completed instruction read (little-endian)
//   fetched_data        - last completed data read (little-endian)
//   request_done        - transfer complete, held until start_request drops
module spi_mem_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_request,
    input  logic        is_write,
    input  logic        is_data_fetch,
    input  logic [2:0]  num_bytes,
    input  logic [31:0] target_address,
    input  logic [31:0] write_value,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        cs1,
    output logic        cs2,
    output logic [31:0] fetched_instruction,
    output logic [31:0] fetched_data,
    output logic        request_done
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;       // 0: sclk low, 1: sclk high
    logic [6:0]  bit_cnt_q, bit_cnt_d;   // bits completed, 0..N
    logic [6:0]  nbits_q, nbits_d;       // N = 32 + 8*num_bytes
    logic        wr_q, wr_d;
    logic        df_q, df_d;
    logic [2:0]  nb_q, nb_d;
    logic [63:0] tx_q, tx_d;             // {cmd, addr, write data}, shifted out MSB first
    logic [31:0] rx_q, rx_d;             // received bits, first byte ends up most significant
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs1_q, cs1_d;
    logic        cs2_q, cs2_d;
    logic        done_q, done_d;
    logic [31:0] finst_q, finst_d;
    logic [31:0] fdata_q, fdata_d;

    logic        nb_legal;
    logic        use_ram;
    logic [7:0]  cmd;
    logic [6:0]  bit_nxt;
    logic [31:0] rx_le;

    assign nb_legal = (num_bytes == 3'd1) || (num_bytes == 3'd2) || (num_bytes == 3'd4);
    assign use_ram  = is_write || is_data_fetch;
    assign cmd      = is_write ? 8'h02 : 8'h03;
    assign bit_nxt  = bit_cnt_q + 7'd1;

    // The shift register holds byte 0 in its most significant used byte;
    // reorder so byte k lands in [8k+7:8k].
    always_comb begin
        rx_le = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(nb_q))
                rx_le[8*k +: 8] = 8'(rx_q >> (8 * (int'(nb_q) - 1 - k)));
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        nbits_d   = nbits_q;
        wr_d      = wr_q;
        df_d      = df_q;
        nb_d      = nb_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs1_d     = cs1_q;
        cs2_d     = cs2_q;
        done_d    = done_q;
        finst_d   = finst_q;
        fdata_d   = fdata_q;

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start_request) begin
                    wr_d = is_write;
                    df_d = is_data_fetch;
                    nb_d = num_bytes;
                    if (!nb_legal) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = CMD;
                        phase_d   = 1'b0;
                        bit_cnt_d = 7'd0;
                        nbits_d   = 7'd32 + 7'({num_bytes, 3'b000});
                        tx_d      = {cmd, target_address[23:0], is_write ? write_value : 32'h0};
                        rx_d      = 32'h0;
                        sclk_d    = 1'b0;
                        mosi_d    = cmd[7];
                        cs1_d     = use_ram;
                        cs2_d     = !use_ram;
                    end
                end
            end

            CMD, ADDR, DATA: begin
                if (!start_request) begin
                    state_d   = IDLE;
                    phase_d   = 1'b0;
                    bit_cnt_d = 7'd0;
                    sclk_d    = 1'b0;
                    mosi_d    = 1'b0;
                    cs1_d     = 1'b1;
                    cs2_d     = 1'b1;
                end else if (state_q == DATA && bit_cnt_q == nbits_q) begin
                    // Tail cycle: bus already released, commit the result.
                    state_d   = DONE;
                    bit_cnt_d = 7'd0;
                    done_d    = 1'b1;
                    if (!wr_q) begin
                        if (df_q) fdata_d = rx_le;
                        else      finst_d = rx_le;
                    end
                end else if (!phase_q) begin
                    sclk_d  = 1'b1;
                    phase_d = 1'b1;
                    if (state_q == DATA && !wr_q)
                        rx_d = {rx_q[30:0], miso};
                end else begin
                    sclk_d    = 1'b0;
                    phase_d   = 1'b0;
                    bit_cnt_d = bit_nxt;
                    tx_d      = {tx_q[62:0], 1'b0};
                    mosi_d    = tx_q[62];
                    if (bit_nxt == 7'd8)  state_d = ADDR;
                    if (bit_nxt == 7'd32) state_d = DATA;
                    if (bit_nxt == nbits_q) begin
                        mosi_d = 1'b0;
                        cs1_d  = 1'b1;
                        cs2_d  = 1'b1;
                    end
                end
            end

            DONE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                cs1_d  = 1'b1;
                cs2_d  = 1'b1;
                if (!start_request) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            bit_cnt_q <= 7'd0;
            nbits_q   <= 7'd0;
            wr_q      <= 1'b0;
            df_q      <= 1'b0;
            nb_q      <= 3'd0;
            tx_q      <= 64'h0;
            rx_q      <= 32'h0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs1_q     <= 1'b1;
            cs2_q     <= 1'b1;
            done_q    <= 1'b0;
            finst_q   <= 32'h0;
            fdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            nbits_q   <= nbits_d;
            wr_q      <= wr_d;
            df_q      <= df_d;
            nb_q      <= nb_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs1_q     <= cs1_d;
            cs2_q     <= cs2_d;
            done_q    <= done_d;
            finst_q   <= finst_d;
            fdata_q   <= fdata_d;
        end
    end

    assign sclk                = sclk_q;
    assign mosi                = mosi_q;
    assign cs1                 = cs1_q;
    assign cs2                 = cs2_q;
    assign request_done        = done_q;
    assign fetched_instruction = finst_q;
    assign fetched_data        = fdata_q;

endmodule

// File: tb/tb_spi_mem_port.sv
module tb_spi_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_request;
    logic        is_write;
    logic        is_data_fetch;
    logic [2:0]  num_bytes;
    logic [31:0] target_address;
    logic [31:0] write_value;
    logic        miso;
    logic        sclk, mosi, cs1, cs2;
    logic [31:0] fetched_instruction, fetched_data;
    logic        request_done;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: last committed results.
    logic [31:0] exp_fi = 32'h0;
    logic [31:0] exp_fd = 32'h0;

    always #5 clk = ~clk;

    spi_mem_port dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_request       (start_request),
        .is_write            (is_write),
        .is_data_fetch       (is_data_fetch),
        .num_bytes           (num_bytes),
        .target_address      (target_address),
        .write_value         (write_value),
        .miso                (miso),
        .sclk                (sclk),
        .mosi                (mosi),
        .cs1                 (cs1),
        .cs2                 (cs2),
        .fetched_instruction (fetched_instruction),
        .fetched_data        (fetched_data),
        .request_done        (request_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_request = 1'b0; is_write = 1'b0; is_data_fetch = 1'b0;
        num_bytes = 3'd0; target_address = 32'h0; write_value = 32'h0; miso = 1'b0;
        tick(); tick();
        n_chk++;
        if ({sclk, mosi, cs1, cs2, request_done} !== 5'b00110 ||
            fetched_instruction !== 32'h0 || fetched_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: sclk/mosi/cs1/cs2/done=%b%b%b%b%b fi=%h fd=%h required 00110 0 0",
                     sclk, mosi, cs1, cs2, request_done, fetched_instruction, fetched_data);
        end
        rst = 1'b0;
        tick();
    endtask

    // Full transfer against a serial-memory model. rdw byte k is the k-th byte
    // the memory returns. hold = extra cycles start_request stays high after done.
    task automatic xfer(input string nm, input bit wr, input bit df, input logic [2:0] nb,
                        input logic [31:0] addr, input logic [31:0] wval,
                        input logic [31:0] rdw, input int hold, input bit scramble);
        int          nbits, edge_n, done_edge, lo1, lo2, rises, j;
        bit          prev_sclk, done_seen, ram;
        logic [63:0] got, exp_stream;
        logic [31:0] exp_res;

        nbits = 32 + 8 * int'(nb);
        ram   = wr || df;
        exp_stream = {(wr ? 8'h02 : 8'h03), addr[23:0], (wr ? wval : 32'h0)};
        exp_res = 32'h0;
        for (int k = 0; k < int'(nb); k++) exp_res[8*k +: 8] = rdw[8*k +: 8];

        start_request = 1'b1; is_write = wr; is_data_fetch = df;
        num_bytes = nb; target_address = addr; write_value = wval; miso = 1'b0;
        edge_n = -1; done_edge = -1; lo1 = 0; lo2 = 0; rises = 0;
        prev_sclk = 1'b0; done_seen = 1'b0; got = 64'h0;
        while (!done_seen && edge_n < 300) begin
            tick();
            edge_n++;
            if (scramble) begin
                is_write = 1'($urandom); is_data_fetch = 1'($urandom);
                num_bytes = 3'($urandom); target_address = $urandom; write_value = $urandom;
            end
            if (!cs1) lo1++;
            if (!cs2) lo2++;
            if (sclk && !prev_sclk) begin
                got = {got[62:0], mosi};
                rises++;
            end
            prev_sclk = sclk;
            if (rises >= 32 && rises < nbits) begin
                j = rises - 32;
                miso = rdw[8 * (j / 8) + 7 - (j % 8)];
            end else begin
                miso = 1'($urandom);
            end
            if (request_done) begin
                done_seen = 1'b1;
                done_edge = edge_n;
            end
        end
        if (wr) begin
            exp_stream = exp_stream >> (64 - nbits);
            got        = got & ((64'h1 << nbits) - 64'h1);
        end else begin
            exp_stream = exp_stream >> 32;
            got        = got >> (nbits - 32);
        end
        if (!wr) begin
            if (df) exp_fd = exp_res;
            else    exp_fi = exp_res;
        end

        n_chk++;
        if (done_edge !== 2 * nbits + 1) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d required %0d", nm, done_edge, 2 * nbits + 1);
        end
        n_chk++;
        if ((ram ? lo2 : lo1) !== 2 * nbits || (ram ? lo1 : lo2) !== 0) begin
            n_fail++;
            $display("FAIL %s cs_low_cycles: cs1=%0d cs2=%0d required sel=%0d other=0",
                     nm, lo1, lo2, 2 * nbits);
        end
        n_chk++;
        if (rises !== nbits || got !== exp_stream) begin
            n_fail++;
            $display("FAIL %s mosi: bits=%0d stream=%h required bits=%0d stream=%h",
                     nm, rises, got, nbits, exp_stream);
        end
        n_chk++;
        if (fetched_instruction !== exp_fi || fetched_data !== exp_fd) begin
            n_fail++;
            $display("FAIL %s fetched: fi=%h fd=%h required fi=%h fd=%h",
                     nm, fetched_instruction, fetched_data, exp_fi, exp_fd);
        end
        n_chk++;
        if ({sclk, mosi, cs1, cs2} !== 4'b0011) begin
            n_fail++;
            $display("FAIL %s done_bus: sclk/mosi/cs1/cs2=%b%b%b%b required 0011",
                     nm, sclk, mosi, cs1, cs2);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            n_chk++;
            if (request_done !== 1'b1 || cs1 !== 1'b1 || cs2 !== 1'b1 || sclk !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold%0d: done=%b cs1=%b cs2=%b sclk=%b required 1 1 1 0",
                         nm, h, request_done, cs1, cs2, sclk);
            end
        end
        start_request = 1'b0;
        tick();
        n_chk++;
        if (request_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_fall: got %b required 0", nm, request_done);
        end
        tick();
    endtask

    task automatic test_instr_read();
        xfer("instr_read", 1'b0, 1'b0, 3'd4, 32'h0000_0010, 32'h0, 32'h0010_0513, 0, 1'b0);
        n_chk++;
        if (fetched_instruction !== 32'h0010_0513) begin
            n_fail++;
            $display("FAIL instr_value: got %h required 00100513", fetched_instruction);
        end
    endtask

    task automatic test_data_read();
        logic [31:0] fi_before;
        fi_before = fetched_instruction;
        xfer("data_read", 1'b0, 1'b1, 3'd1, 32'h0000_0123, 32'h0, 32'h0000_00A5, 0, 1'b0);
        n_chk++;
        if (fetched_data !== 32'h0000_00A5 || fetched_instruction !== fi_before) begin
            n_fail++;
            $display("FAIL data_value: fd=%h fi=%h required fd=000000a5 fi=%h",
                     fetched_data, fetched_instruction, fi_before);
        end
    endtask

    task automatic test_write();
        xfer("write", 1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'hBEEF_0000, 32'h0, 0, 1'b0);
    endtask

    task automatic test_handshake();
        xfer("handshake", 1'b0, 1'b1, 3'd2, 32'h00AB_CDEF, 32'h0, 32'h0000_5AC3, 5, 1'b1);
        n_chk++;
        repeat (4) tick();
        if (cs1 !== 1'b1 || cs2 !== 1'b1 || request_done !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake_idle: cs1=%b cs2=%b done=%b required 1 1 0", cs1, cs2, request_done);
        end
    endtask

    task automatic test_random();
        logic [2:0] nbs [3] = '{3'd1, 3'd2, 3'd4};
        for (int t = 0; t < 12; t++) begin
            xfer("random", 1'($urandom), 1'($urandom), nbs[$urandom_range(0, 2)],
                 $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'b1);
        end
    endtask

    task automatic test_abort(input bit use_rst);
        start_request = 1'b1; is_write = 1'b0; is_data_fetch = 1'b0;
        num_bytes = 3'd4; target_address = 32'h0012_3456; write_value = 32'h0;
        repeat (40) begin
            tick();
            miso = 1'($urandom);
        end
        if (use_rst) rst = 1'b1;
        else         start_request = 1'b0;
        tick();
        if (use_rst) begin
            exp_fi = 32'h0;
            exp_fd = 32'h0;
        end
        n_chk++;
        if ({sclk, cs1, cs2, request_done} !== 4'b0110 ||
            fetched_instruction !== exp_fi || fetched_data !== exp_fd ||
            (use_rst && mosi !== 1'b0)) begin
            n_fail++;
            $display("FAIL abort(rst=%0d): sclk/cs1/cs2/done=%b%b%b%b mosi=%b fi=%h fd=%h required 0110 fi=%h fd=%h",
                     use_rst, sclk, cs1, cs2, request_done, mosi,
                     fetched_instruction, fetched_data, exp_fi, exp_fd);
        end
        rst = 1'b0; start_request = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        logic [2:0] bad [5] = '{3'd3, 3'd0, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 5; i++) begin
            start_request = 1'b1; is_write = 1'($urandom); is_data_fetch = 1'($urandom);
            num_bytes = bad[i]; target_address = $urandom; write_value = $urandom;
            tick();
            n_chk++;
            if (request_done !== 1'b1 || cs1 !== 1'b1 || cs2 !== 1'b1 || sclk !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal nb=%0d: done=%b cs1=%b cs2=%b sclk=%b required 1 1 1 0",
                         bad[i], request_done, cs1, cs2, sclk);
            end
            tick();
            n_chk++;
            if (cs1 !== 1'b1 || cs2 !== 1'b1 || fetched_instruction !== exp_fi ||
                fetched_data !== exp_fd) begin
                n_fail++;
                $display("FAIL illegal_quiet nb=%0d: cs1=%b cs2=%b fi=%h fd=%h required 1 1 %h %h",
                         bad[i], cs1, cs2, fetched_instruction, fetched_data, exp_fi, exp_fd);
            end
            start_request = 1'b0;
            tick();
            n_chk++;
            if (request_done !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_fall nb=%0d: done=%b required 0", bad[i], request_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_data_read();
        test_write();
        test_handshake();
        test_random();
        test_abort(1'b0);
        test_illegal();
        test_instr_read();
        test_abort(1'b1);
        test_data_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
